steuerwerk: RTL and testbench



---
 rtl/steuerwerk_pkg.sv | 32 +++
 rtl/steuerwerk_if.sv | 47 ++++
 rtl/steuerwerk_timeout.sv | 27 ++
 rtl/steuerwerk.sv | 112 +++++++++++
 tb/tb_steuerwerk.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/steuerwerk_pkg.sv
// Shared types for the steuerwerk control FSM: state encoding and trap causes.
// The IRQ state exists only when STEUERWERK_INTERRUPT_EN is defined.
package steuerwerk_pkg;

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_DECODE     = 4'd1,
    S_ALU_START  = 4'd2,
    S_ALU_WAIT   = 4'd3,
    S_WB_JUMP    = 4'd4,
    S_WB_STORE   = 4'd5,
    S_WB_LOAD    = 4'd6,
    S_WB_DEFAULT = 4'd7,
    S_TRAP       = 4'd8
`ifdef STEUERWERK_INTERRUPT_EN
    , S_IRQ      = 4'd9
`endif
  } state_e;

  typedef logic [1:0] trap_cause_t;

  localparam trap_cause_t TRAP_NONE     = 2'b00;
  localparam trap_cause_t TRAP_ILLEGAL  = 2'b01;
  localparam trap_cause_t TRAP_FETCH_TO = 2'b10;
  localparam trap_cause_t TRAP_EXEC_TO  = 2'b11;

  // States that wait on an external handshake and are therefore guarded by the timeout.
  function automatic logic is_wait_state(input state_e s);
    return s inside {S_FETCH, S_ALU_WAIT, S_WB_STORE, S_WB_LOAD};
  endfunction

endpackage

// File: rtl/steuerwerk_if.sv
// Control bundle between steuerwerk (master) and the Hans datapath (slave).
// Interrupt request/acknowledge exist only when STEUERWERK_INTERRUPT_EN is defined.
interface steuerwerk_if #(
  parameter int RETIRE_WIDTH = 32
);
  logic BefehlGeladen, DatenGeladen, DatenGespeichert, ALUFertig;
  logic LoadBefehl, StoreBefehl, JALBefehl;
  logic UnbedingterSprungBefehl, BedingterSprungBefehl, Bedingung;
  logic UngueltigerBefehl, TrapQuittung;
  logic LoadBefehlSignal, DekodierSignal, ALUStartSignal, RegisterSchreibSignal;
  logic LoadDatenSignal, StoreDatenSignal, PCSignal, PCSprungSignal;
  logic                    TrapSignal;
  logic [1:0]              TrapUrsache;
  logic [RETIRE_WIDTH-1:0] BefehleAusgefuehrt;
`ifdef STEUERWERK_INTERRUPT_EN
  logic InterruptAnfrage, InterruptAnnahme;
`endif

  modport master (
    input  BefehlGeladen, DatenGeladen, DatenGespeichert, ALUFertig,
    input  LoadBefehl, StoreBefehl, JALBefehl,
    input  UnbedingterSprungBefehl, BedingterSprungBefehl, Bedingung,
    input  UngueltigerBefehl, TrapQuittung,
    output LoadBefehlSignal, DekodierSignal, ALUStartSignal, RegisterSchreibSignal,
    output LoadDatenSignal, StoreDatenSignal, PCSignal, PCSprungSignal,
    output TrapSignal, TrapUrsache, BefehleAusgefuehrt
`ifdef STEUERWERK_INTERRUPT_EN
    , input  InterruptAnfrage
    , output InterruptAnnahme
`endif
  );

  modport slave (
    output BefehlGeladen, DatenGeladen, DatenGespeichert, ALUFertig,
    output LoadBefehl, StoreBefehl, JALBefehl,
    output UnbedingterSprungBefehl, BedingterSprungBefehl, Bedingung,
    output UngueltigerBefehl, TrapQuittung,
    input  LoadBefehlSignal, DekodierSignal, ALUStartSignal, RegisterSchreibSignal,
    input  LoadDatenSignal, StoreDatenSignal, PCSignal, PCSprungSignal,
    input  TrapSignal, TrapUrsache, BefehleAusgefuehrt
`ifdef STEUERWERK_INTERRUPT_EN
    , output InterruptAnfrage
    , input  InterruptAnnahme
`endif
  );

endinterface

// File: rtl/steuerwerk_timeout.sv
// Handshake wait counter: counts cycles spent in a waiting state and flags
// the last permitted cycle so the FSM can divert to TRAP.
module steuerwerk_timeout #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 200
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expired
);
  localparam logic [WIDTH-1:0] LAST = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_count <= '0;
    else if (i_clear) r_count <= '0;
    else if (i_count) r_count <= r_count + 1'b1;
  end

  assign o_expired = i_count && (r_count == LAST);

endmodule

// File: rtl/steuerwerk.sv
// steuerwerk: multi-cycle fetch/decode/execute/write-back sequencer for the Hans core
// with handshake timeouts, traps and a retire counter. Macro: STEUERWERK_INTERRUPT_EN.
module steuerwerk
  import steuerwerk_pkg::*;
#(
  parameter int TIMEOUT_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int RETIRE_WIDTH   = 32
) (
  input logic          i_clk,
  input logic          i_rst_n,
  steuerwerk_if.master io_bus
);
  state_e                  r_state, w_next, w_wb_sel, w_done_next;
  trap_cause_t             r_cause, w_cause;
  logic [RETIRE_WIDTH-1:0] r_retired;
  logic                    w_expired, w_pc;

  steuerwerk_timeout #(
    .WIDTH (TIMEOUT_WIDTH),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (w_next != r_state),
    .i_count   (is_wait_state(r_state)),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    if (io_bus.UnbedingterSprungBefehl || io_bus.BedingterSprungBefehl) w_wb_sel = S_WB_JUMP;
    else if (io_bus.StoreBefehl)                                        w_wb_sel = S_WB_STORE;
    else if (io_bus.LoadBefehl)                                         w_wb_sel = S_WB_LOAD;
    else                                                                w_wb_sel = S_WB_DEFAULT;
  end

`ifdef STEUERWERK_INTERRUPT_EN
  assign w_done_next = io_bus.InterruptAnfrage ? S_IRQ : S_FETCH;
`else
  assign w_done_next = S_FETCH;
`endif

  // Handshakes are tested before expiry so a last-cycle arrival still completes.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    w_next  = r_state;
    w_cause = TRAP_NONE;
    case (r_state)
      S_FETCH:
        if (io_bus.BefehlGeladen) w_next = S_DECODE;
        else if (w_expired) begin w_next = S_TRAP; w_cause = TRAP_FETCH_TO; end
      S_DECODE:
        if (io_bus.UngueltigerBefehl) begin w_next = S_TRAP; w_cause = TRAP_ILLEGAL; end
        else w_next = S_ALU_START;
      S_ALU_START:
        w_next = io_bus.ALUFertig ? w_wb_sel : S_ALU_WAIT;
      S_ALU_WAIT:
        if (io_bus.ALUFertig) w_next = w_wb_sel;
        else if (w_expired) begin w_next = S_TRAP; w_cause = TRAP_EXEC_TO; end
      S_WB_JUMP, S_WB_DEFAULT:
        w_next = w_done_next;
      S_WB_STORE:
        if (io_bus.DatenGespeichert) w_next = w_done_next;
        else if (w_expired) begin w_next = S_TRAP; w_cause = TRAP_EXEC_TO; end
      S_WB_LOAD:
        if (io_bus.DatenGeladen) w_next = S_WB_DEFAULT;
        else if (w_expired) begin w_next = S_TRAP; w_cause = TRAP_EXEC_TO; end
      S_TRAP:
        if (io_bus.TrapQuittung) w_next = S_FETCH;
      default:
        w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cause   <= TRAP_NONE;
      r_retired <= '0;
    end else begin
      if (w_next == S_TRAP && r_state != S_TRAP)      r_cause <= w_cause;
      else if (r_state == S_TRAP && w_next != S_TRAP) r_cause <= TRAP_NONE;
      if (w_pc) r_retired <= r_retired + 1'b1;
    end
  end

  always_comb begin
    w_pc = (r_state == S_WB_JUMP) || (r_state == S_WB_DEFAULT) ||
           ((r_state == S_WB_STORE) && io_bus.DatenGespeichert);
    io_bus.LoadBefehlSignal      = (r_state == S_FETCH);
    io_bus.DekodierSignal        = (r_state == S_DECODE);
    io_bus.ALUStartSignal        = (r_state == S_ALU_START);
    io_bus.StoreDatenSignal      = (r_state == S_WB_STORE);
    io_bus.LoadDatenSignal       = (r_state == S_WB_LOAD);
    io_bus.TrapSignal            = (r_state == S_TRAP);
    io_bus.RegisterSchreibSignal = (r_state == S_WB_DEFAULT) ||
                                   ((r_state == S_WB_JUMP) && io_bus.JALBefehl);
    io_bus.PCSignal              = w_pc;
    io_bus.PCSprungSignal        = io_bus.UnbedingterSprungBefehl ||
                                   (io_bus.BedingterSprungBefehl && io_bus.Bedingung);
    io_bus.TrapUrsache           = r_cause;
    io_bus.BefehleAusgefuehrt    = r_retired;
`ifdef STEUERWERK_INTERRUPT_EN
    io_bus.InterruptAnnahme      = (r_state == S_IRQ);
`endif
  end

endmodule

// File: tb/tb_steuerwerk.sv
// Scoreboard bench for steuerwerk: each driven cycle queues its expected strobes,
// trap cause and retire count; a negedge monitor pops and compares them.
module tb_steuerwerk;

  localparam logic [12:0] B_BG = 13'h0001, B_DG = 13'h0002, B_DS  = 13'h0004, B_AF  = 13'h0008,
                          B_LD = 13'h0010, B_ST = 13'h0020, B_JAL = 13'h0040, B_UJ  = 13'h0080,
                          B_BJ = 13'h0100, B_BD = 13'h0200, B_UG  = 13'h0400, B_TQ  = 13'h0800,
                          B_IRQ = 13'h1000;

  localparam logic [9:0] X_F = 10'h001, X_D = 10'h002, X_A = 10'h004, X_W = 10'h008,
                         X_L = 10'h010, X_S = 10'h020, X_P = 10'h040, X_T = 10'h080,
                         X_J = 10'h100, X_I = 10'h200;

  localparam logic [1:0] C_NONE = 2'b00, C_ILL = 2'b01, C_FTO = 2'b10, C_XTO = 2'b11;

  typedef struct packed {
    logic [9:0]  strb;
    logic [1:0]  cause;
    logic [31:0] ret;
    logic [31:0] idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_ret = '0;
  logic [31:0] n_cyc   = '0;
  exp_t        exp_q[$];

  steuerwerk_if #(.RETIRE_WIDTH(32)) bus ();

  steuerwerk #(
    .TIMEOUT_WIDTH  (8),
    .TIMEOUT_CYCLES (5),
    .RETIRE_WIDTH   (32)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  logic [8:0] w_obs;
  assign w_obs = {bus.PCSprungSignal, bus.TrapSignal, bus.PCSignal, bus.StoreDatenSignal,
                  bus.LoadDatenSignal, bus.RegisterSchreibSignal, bus.ALUStartSignal,
                  bus.DekodierSignal, bus.LoadBefehlSignal};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue what the DUT must show during it.
  task automatic cyc(input logic [12:0] stim, input logic [9:0] strb, input logic [1:0] cause);
    bus.BefehlGeladen           = stim[0];
    bus.DatenGeladen            = stim[1];
    bus.DatenGespeichert        = stim[2];
    bus.ALUFertig               = stim[3];
    bus.LoadBefehl              = stim[4];
    bus.StoreBefehl             = stim[5];
    bus.JALBefehl               = stim[6];
    bus.UnbedingterSprungBefehl = stim[7];
    bus.BedingterSprungBefehl   = stim[8];
    bus.Bedingung               = stim[9];
    bus.UngueltigerBefehl       = stim[10];
    bus.TrapQuittung            = stim[11];
`ifdef STEUERWERK_INTERRUPT_EN
    bus.InterruptAnfrage        = stim[12];
`endif
    exp_q.push_back('{strb: strb, cause: cause, ret: exp_ret, idx: n_cyc});
    if (strb[6]) exp_ret = exp_ret + 1;
    n_cyc = n_cyc + 1;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check($sformatf("strb@%0d", e.idx), 32'(w_obs), 32'(e.strb[8:0]));
      check($sformatf("cause@%0d", e.idx), 32'(bus.TrapUrsache), 32'(e.cause));
      check($sformatf("retired@%0d", e.idx), bus.BefehleAusgefuehrt, e.ret);
`ifdef STEUERWERK_INTERRUPT_EN
      check($sformatf("irqack@%0d", e.idx), 32'(bus.InterruptAnnahme), 32'(e.strb[9]));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.BefehlGeladen = 0; bus.DatenGeladen = 0; bus.DatenGespeichert = 0; bus.ALUFertig = 0;
    bus.LoadBefehl = 0; bus.StoreBefehl = 0; bus.JALBefehl = 0;
    bus.UnbedingterSprungBefehl = 0; bus.BedingterSprungBefehl = 0; bus.Bedingung = 0;
    bus.UngueltigerBefehl = 0; bus.TrapQuittung = 0;
`ifdef STEUERWERK_INTERRUPT_EN
    bus.InterruptAnfrage = 0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_strb", 32'(w_obs), 32'(X_F));
    check("reset_cause", 32'(bus.TrapUrsache), 32'(C_NONE));
    check("reset_retired", bus.BefehleAusgefuehrt, 32'd0);
    rst_n = 1'b1;

    // Back-to-back ALU ops with both handshakes tied high: 4 cycles each.
    for (int i = 0; i < 10; i++) begin
      cyc(B_BG | B_AF, X_F, C_NONE);
      cyc(B_BG | B_AF, X_D, C_NONE);
      cyc(B_BG | B_AF, X_A, C_NONE);
      cyc(B_BG | B_AF, X_W | X_P, C_NONE);
    end
    check("retired_after_40", bus.BefehleAusgefuehrt, 32'd10);

    // Load, data arriving on the third WB_LOAD cycle; early DatenGeladen ignored.
    cyc(B_BG | B_LD | B_DG, X_F, C_NONE);
    cyc(B_LD | B_DG, X_D, C_NONE);
    cyc(B_LD | B_AF, X_A, C_NONE);
    cyc(B_LD, X_L, C_NONE);
    cyc(B_LD, X_L, C_NONE);
    cyc(B_LD | B_DG, X_L, C_NONE);
    cyc(B_LD, X_W | X_P, C_NONE);

    // Fetch timeout: five FETCH cycles, then TRAP until acknowledged.
    repeat (5) cyc('0, X_F, C_NONE);
    cyc('0, X_T, C_FTO);
    cyc('0, X_T, C_FTO);
    cyc(B_TQ, X_T, C_FTO);

    // Illegal instruction: no ALU start, no retire, single TRAP cycle.
    cyc(B_BG, X_F, C_NONE);
    cyc(B_UG, X_D, C_NONE);
    cyc(B_TQ, X_T, C_ILL);

    // Handshakes arriving on the last permitted cycle win over the timeout.
    repeat (4) cyc('0, X_F, C_NONE);
    cyc(B_BG, X_F, C_NONE);
    cyc(B_ST, X_D, C_NONE);
    cyc(B_ST, X_A, C_NONE);
    repeat (4) cyc(B_ST, '0, C_NONE);
    cyc(B_ST | B_AF, '0, C_NONE);
    cyc(B_ST | B_DS, X_S | X_P, C_NONE);

    // Store timeout.
    cyc(B_BG | B_ST | B_DS, X_F, C_NONE);
    cyc(B_ST, X_D, C_NONE);
    cyc(B_ST | B_AF, X_A, C_NONE);
    repeat (5) cyc(B_ST, X_S, C_NONE);
    cyc(B_TQ, X_T, C_XTO);

    // Conditional jump not taken, outranking store.
    cyc(B_BG | B_BJ | B_ST, X_F, C_NONE);
    cyc(B_BJ | B_ST, X_D, C_NONE);
    cyc(B_BJ | B_ST | B_AF, X_A, C_NONE);
    cyc(B_BJ | B_ST, X_P, C_NONE);
    // JAL: register write during WB_JUMP.
    cyc(B_BG | B_UJ | B_JAL, X_F | X_J, C_NONE);
    cyc(B_UJ | B_JAL, X_D | X_J, C_NONE);
    cyc(B_UJ | B_JAL | B_AF, X_A | X_J, C_NONE);
    cyc(B_UJ | B_JAL, X_W | X_P | X_J, C_NONE);
    // Conditional jump taken.
    cyc(B_BG | B_BJ | B_BD, X_F | X_J, C_NONE);
    cyc(B_BJ | B_BD, X_D | X_J, C_NONE);
    cyc(B_BJ | B_BD | B_AF, X_A | X_J, C_NONE);
    cyc(B_BJ | B_BD, X_P | X_J, C_NONE);
    // Store outranks load.
    cyc(B_BG | B_ST | B_LD, X_F, C_NONE);
    cyc(B_ST | B_LD, X_D, C_NONE);
    cyc(B_ST | B_LD | B_AF, X_A, C_NONE);
    cyc(B_ST | B_LD | B_DS, X_S | X_P, C_NONE);

`ifdef STEUERWERK_INTERRUPT_EN
    cyc(B_BG, X_F, C_NONE);
    cyc('0, X_D, C_NONE);
    cyc(B_AF, X_A, C_NONE);
    cyc(B_IRQ, X_W | X_P, C_NONE);
    cyc('0, X_I, C_NONE);
    cyc('0, X_F, C_NONE);
    cyc(B_BG | B_IRQ, X_F, C_NONE);
    cyc(B_UG | B_IRQ, X_D, C_NONE);
    cyc(B_TQ | B_IRQ, X_T, C_ILL);
    cyc('0, X_F, C_NONE);
`endif

    // Asynchronous reset in the middle of WB_STORE.
    cyc(B_BG | B_ST, X_F, C_NONE);
    cyc(B_ST, X_D, C_NONE);
    cyc(B_ST | B_AF, X_A, C_NONE);
    cyc(B_ST, X_S, C_NONE);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_strb", 32'(w_obs), 32'(X_F));
    check("async_rst_retired", bus.BefehleAusgefuehrt, 32'd0);
    check("async_rst_cause", 32'(bus.TrapUrsache), 32'(C_NONE));
    exp_ret = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(B_BG | B_AF, X_F, C_NONE);
    cyc(B_BG | B_AF, X_D, C_NONE);
    cyc(B_BG | B_AF, X_A, C_NONE);
    cyc(B_BG | B_AF, X_W | X_P, C_NONE);
    cyc('0, X_F, C_NONE);

    @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
